instr_fetch_decode: RTL

//  Sequencer directly downstream of instruction memory: walks instrNumber from 0, pulls each 32-bit word off

---
 rtl/sm_pkg.sv | 33 +++
 rtl/instr_fetch_decode_if.sv | 43 ++++
 rtl/instr_fetch_decode_field.sv | 36 +++
 rtl/instr_fetch_decode.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// ============================================================================
// Module : sm_pkg
// Brief  : Opcodes, instruction field positions and sequencer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sm_pkg;

   localparam logic [7:0] OP_ADD       = 8'h00;
   localparam logic [7:0] OP_SUB       = 8'h01;
   localparam logic [7:0] OP_TRANSPOSE = 8'h02;
   localparam logic [7:0] OP_SCALE     = 8'h03;
   localparam logic [7:0] OP_MULT      = 8'h04;
   localparam logic [7:0] OP_STOP      = 8'hFF;

   // Field slot index within the word, counted in FIELD_WIDTH units from the LSB
   localparam int OPCODE_FIELD = 3;
   localparam int DEST_FIELD   = 2;
   localparam int SRC1_FIELD   = 1;
   localparam int SRC2_FIELD   = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_decode_if.sv
// ============================================================================
// Module : instr_fetch_decode_if
// Brief  : Instruction-memory, operation-issue and control bundle of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_fetch_decode_if #(
   parameter int PC_WIDTH    = 3,
   parameter int INSTR_WIDTH = 32,
   parameter int FIELD_WIDTH = 8
);
   logic                   start;
   logic                   nIMemEnable;
   logic [PC_WIDTH-1:0]    instrNumber;
   logic [INSTR_WIDTH-1:0] instrMemLine;
   logic                   opValid;
   logic                   opReady;
   logic [FIELD_WIDTH-1:0] opCode;
   logic [FIELD_WIDTH-1:0] opDest;
   logic [FIELD_WIDTH-1:0] opSrc1;
   logic [FIELD_WIDTH-1:0] opSrc2;
   logic                   opSrc2Used;
   logic                   busy;
   logic                   done;
   logic                   illegalOp;
   logic                   pcOverrun;

   modport master (
      input  start, instrMemLine, opReady,
      output nIMemEnable, instrNumber, opValid, opCode, opDest, opSrc1, opSrc2,
             opSrc2Used, busy, done, illegalOp, pcOverrun
   );

   modport slave (
      output start, instrMemLine, opReady,
      input  nIMemEnable, instrNumber, opValid, opCode, opDest, opSrc1, opSrc2,
             opSrc2Used, busy, done, illegalOp, pcOverrun
   );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_decode_field.sv
// ============================================================================
// Module : instr_field_decode
// Brief  : Combinational split of an instruction word into fields and class flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_field_decode
   import sm_pkg::*;
#(
   parameter int INSTR_WIDTH = 32,
   parameter int FIELD_WIDTH = 8
) (
   input  logic [INSTR_WIDTH-1:0] word,
   output logic [FIELD_WIDTH-1:0] opcode,
   output logic [FIELD_WIDTH-1:0] dest,
   output logic [FIELD_WIDTH-1:0] src1,
   output logic [FIELD_WIDTH-1:0] src2,
   output logic                   isStop,
   output logic                   isLegal,
   output logic                   src2Used
);

   assign opcode = word[OPCODE_FIELD*FIELD_WIDTH +: FIELD_WIDTH];
   assign dest   = word[DEST_FIELD*FIELD_WIDTH   +: FIELD_WIDTH];
   assign src1   = word[SRC1_FIELD*FIELD_WIDTH   +: FIELD_WIDTH];
   assign src2   = word[SRC2_FIELD*FIELD_WIDTH   +: FIELD_WIDTH];

   // Opcodes are dense from OP_ADD, so legality is a single bound check
   assign isStop   = (opcode == FIELD_WIDTH'(OP_STOP));
   assign isLegal  = (opcode <= FIELD_WIDTH'(OP_MULT));
   assign src2Used = (opcode != FIELD_WIDTH'(OP_TRANSPOSE));

endmodule

`default_nettype wire

// File: rtl/instr_fetch_decode.sv
// ============================================================================
// Module : instr_fetch_decode
// Brief  : Fetch/decode sequencer issuing one matrix operation at a time.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_decode
   import sm_pkg::*;
#(
   parameter int PC_WIDTH    = 3,
   parameter int INSTR_WIDTH = 32,
   parameter int FIELD_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 nReset,
   instr_fetch_decode_if.master bus
);

   localparam logic [PC_WIDTH-1:0] c_pcLast = '1;

   state_t                 r_state;
   logic [PC_WIDTH-1:0]    r_pc;
   logic                   r_nIMemEnable;
   logic                   r_opValid;
   logic [FIELD_WIDTH-1:0] r_opCode;
   logic [FIELD_WIDTH-1:0] r_opDest;
   logic [FIELD_WIDTH-1:0] r_opSrc1;
   logic [FIELD_WIDTH-1:0] r_opSrc2;
   logic                   r_src2Used;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_illegalOp;
   logic                   r_pcOverrun;

   logic [FIELD_WIDTH-1:0] w_opcode;
   logic [FIELD_WIDTH-1:0] w_dest;
   logic [FIELD_WIDTH-1:0] w_src1;
   logic [FIELD_WIDTH-1:0] w_src2;
   logic                   w_isStop;
   logic                   w_isLegal;
   logic                   w_src2Used;

   instr_field_decode #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .FIELD_WIDTH (FIELD_WIDTH)
   ) u_decode (
      .word     (bus.instrMemLine),
      .opcode   (w_opcode),
      .dest     (w_dest),
      .src1     (w_src1),
      .src2     (w_src2),
      .isStop   (w_isStop),
      .isLegal  (w_isLegal),
      .src2Used (w_src2Used)
   );

   // Outputs are registered alongside the state so each one tracks its state exactly
   always_ff @(posedge clk) begin
      if (!nReset) begin
         r_state       <= ST_IDLE;
         r_pc          <= '0;
         r_nIMemEnable <= 1'b1;
         r_opValid     <= 1'b0;
         r_opCode      <= '0;
         r_opDest      <= '0;
         r_opSrc1      <= '0;
         r_opSrc2      <= '0;
         r_src2Used    <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_illegalOp   <= 1'b0;
         r_pcOverrun   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_state       <= ST_FETCH;
                  r_nIMemEnable <= 1'b0;
                  r_busy        <= 1'b1;
               end
            end
            ST_FETCH: begin
               r_state       <= ST_WAIT;
               r_nIMemEnable <= 1'b1;
            end
            ST_WAIT: begin
               r_opCode   <= w_opcode;
               r_opDest   <= w_dest;
               r_opSrc1   <= w_src1;
               r_opSrc2   <= w_src2;
               r_src2Used <= w_src2Used;
               if (w_isStop) begin
                  r_state <= ST_HALT;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_isLegal) begin
                  r_state   <= ST_ISSUE;
                  r_opValid <= 1'b1;
               end else begin
                  r_state     <= ST_HALT;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_illegalOp <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (bus.opReady) begin
                  r_opValid <= 1'b0;
                  if (r_pc == c_pcLast) begin
                     r_state     <= ST_HALT;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_pcOverrun <= 1'b1;
                  end else begin
                     r_state       <= ST_FETCH;
                     r_pc          <= r_pc + PC_WIDTH'(1);
                     r_nIMemEnable <= 1'b0;
                  end
               end
            end
            ST_HALT: begin
               if (bus.start) begin
                  r_state       <= ST_FETCH;
                  r_pc          <= '0;
                  r_nIMemEnable <= 1'b0;
                  r_busy        <= 1'b1;
                  r_done        <= 1'b0;
                  r_illegalOp   <= 1'b0;
                  r_pcOverrun   <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.nIMemEnable = r_nIMemEnable;
   assign bus.instrNumber = r_pc;
   assign bus.opValid     = r_opValid;
   assign bus.opCode      = r_opCode;
   assign bus.opDest      = r_opDest;
   assign bus.opSrc1      = r_opSrc1;
   assign bus.opSrc2      = r_opSrc2;
   assign bus.opSrc2Used  = r_src2Used;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.illegalOp   = r_illegalOp;
   assign bus.pcOverrun   = r_pcOverrun;

endmodule

`default_nettype wire
